// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED pattern sequencer: phase encoding, mode
// encoding and the pattern generator that turns sequencer state into LEDs.
package led_seq_pkg;

  typedef enum logic [2:0] {
    FILL_L  = 3'd0,
    DRAIN_L = 3'd1,
    BLINK   = 3'd2,
    FILL_R  = 3'd3,
    DRAIN_R = 3'd4
  } phase_t;

  localparam logic [1:0] MODE_SHOW  = 2'd0;
  localparam logic [1:0] MODE_LBAR  = 2'd1;
  localparam logic [1:0] MODE_BLINK = 2'd2;
  localparam logic [1:0] MODE_RBAR  = 2'd3;

  // n is in 0..32; n == 32 must yield all ones without relying on shift overflow.
  function automatic logic [31:0] low_mask(input logic [5:0] n);
    if (n >= 6'd32) return '1;
    return (32'd1 << n) - 32'd1;
  endfunction

  function automatic logic [31:0] led_pattern(input phase_t     ph,
                                              input logic [5:0] k,
                                              input logic       blink_on,
                                              input logic [5:0] width);
    logic [31:0] pat;
    pat = '0;
    case (ph)
      FILL_L, DRAIN_L: pat = low_mask(k);
      BLINK:           pat = blink_on ? low_mask(width) : '0;
      FILL_R, DRAIN_R: pat = low_mask(k) << (width - k);
      default:         pat = '0;
    endcase
    return pat;
  endfunction

endpackage

// File: rtl/led_pattern_seq_step_timer.sv
// Step timer: counts enabled cycles and pulses TICK on the last cycle of each
// DIV-cycle step period.
module step_timer #(
  parameter int unsigned DIV = 1
) (
  input  logic CLOCK,
  input  logic RESET,
  input  logic EN,
  output logic TICK
);

  localparam int TW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [TW-1:0] TERM = TW'(DIV - 1);

  logic [TW-1:0] cnt;

  assign TICK = EN && (cnt == TERM);

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      cnt <= '0;
    end else if (EN) begin
      if (cnt == TERM) cnt <= '0;
      else             cnt <= cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_pattern_seq.sv
// LED pattern sequencer: walks fill/drain/blink phases selected by MODE,
// advancing one pattern per timer tick and flagging each loop restart on WRAP.
module led_pattern_seq
  import led_seq_pkg::*;
#(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned DIV    = 1,
  parameter int unsigned BLINKS = 2
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             EN,
  input  logic [1:0]       MODE,
  output logic [WIDTH-1:0] LED,
  output logic             WRAP
);

  localparam int KW = $clog2(WIDTH + 1);
  localparam logic [KW-1:0] K_FULL = KW'(WIDTH);
  localparam logic [KW-1:0] K_ONE  = KW'(1);
  localparam logic [3:0]    B_LAST = 4'(BLINKS - 1);

  logic          tick;
  logic [1:0]    mode_r;
  phase_t        phase, phase_n, phase_f, phase_d;
  logic [KW-1:0] k, k_n, k_f, k_d;
  logic          blink_on, bon_n, bon_f, bon_d;
  logic [3:0]    bcnt, bcnt_n, bcnt_d;
  logic          at_end;
  logic [WIDTH-1:0] led_d;

  step_timer #(.DIV(DIV)) u_timer (
    .CLOCK (CLOCK),
    .RESET (RESET),
    .EN    (EN),
    .TICK  (tick)
  );

  // First pattern of the mode currently presented on MODE.
  always_comb begin
    phase_f = FILL_L;
    k_f     = K_ONE;
    bon_f   = 1'b0;
    case (MODE)
      MODE_BLINK: begin
        phase_f = BLINK;
        k_f     = '0;
        bon_f   = 1'b1;
      end
      MODE_RBAR: phase_f = FILL_R;
      default: ;
    endcase
  end

  always_comb begin
    phase_n = phase;
    k_n     = k;
    bon_n   = blink_on;
    bcnt_n  = bcnt;
    at_end  = 1'b0;
    case (phase)
      FILL_L: begin
        if (k == K_FULL) begin
          phase_n = DRAIN_L;
          k_n     = k - K_ONE;
        end else begin
          k_n = k + K_ONE;
        end
      end
      DRAIN_L: begin
        if (k == '0) begin
          if (mode_r == MODE_LBAR) begin
            at_end = 1'b1;
          end else begin
            phase_n = BLINK;
            bon_n   = 1'b1;
            bcnt_n  = '0;
          end
        end else begin
          k_n = k - K_ONE;
        end
      end
      BLINK: begin
        if (blink_on) begin
          bon_n = 1'b0;
        end else if (bcnt == B_LAST) begin
          if (mode_r == MODE_BLINK) begin
            at_end = 1'b1;
          end else begin
            phase_n = FILL_R;
            k_n     = K_ONE;
          end
        end else begin
          bon_n  = 1'b1;
          bcnt_n = bcnt + 4'd1;
        end
      end
      FILL_R: begin
        if (k == K_FULL) begin
          phase_n = DRAIN_R;
          k_n     = k - K_ONE;
        end else begin
          k_n = k + K_ONE;
        end
      end
      DRAIN_R: begin
        if (k == '0) at_end = 1'b1;
        else         k_n    = k - K_ONE;
      end
      default: at_end = 1'b1;
    endcase
    if (at_end) begin
      phase_n = phase_f;
      k_n     = k_f;
      bon_n   = bon_f;
      bcnt_n  = '0;
    end
  end

  // Reset and loop restart both land on the first pattern of MODE.
  always_comb begin
    phase_d = RESET ? phase_f : phase_n;
    k_d     = RESET ? k_f     : k_n;
    bon_d   = RESET ? bon_f   : bon_n;
    bcnt_d  = RESET ? 4'd0    : bcnt_n;
    led_d   = WIDTH'(led_pattern(phase_d, 6'(k_d), bon_d, 6'(WIDTH)));
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      mode_r   <= MODE;
      phase    <= phase_d;
      k        <= k_d;
      blink_on <= bon_d;
      bcnt     <= bcnt_d;
      LED      <= led_d;
      WRAP     <= 1'b0;
    end else begin
      WRAP <= tick && at_end;
      if (tick) begin
        phase    <= phase_d;
        k        <= k_d;
        blink_on <= bon_d;
        bcnt     <= bcnt_d;
        LED      <= led_d;
        if (at_end) mode_r <= MODE;
      end
    end
  end

endmodule

// File: tb/tb_led_pattern_seq.sv
// Directed bench for led_pattern_seq: one instance stepping every cycle and
// one with a four-cycle step period.
module tb_led_pattern_seq;

  logic       clk;
  logic       rst1, en1, rst4, en4;
  logic [1:0] mode1, mode4;
  logic [7:0] led1, led4;
  logic       wrap1, wrap4;

  int total  = 0;
  int passed = 0;
  int failed = 0;

  logic [7:0] show [36] = '{
    8'h01, 8'h03, 8'h07, 8'h0F, 8'h1F, 8'h3F, 8'h7F, 8'hFF,
    8'h7F, 8'h3F, 8'h1F, 8'h0F, 8'h07, 8'h03, 8'h01, 8'h00,
    8'hFF, 8'h00, 8'hFF, 8'h00,
    8'h80, 8'hC0, 8'hE0, 8'hF0, 8'hF8, 8'hFC, 8'hFE, 8'hFF,
    8'hFE, 8'hFC, 8'hF8, 8'hF0, 8'hE0, 8'hC0, 8'h80, 8'h00
  };

  led_pattern_seq #(.WIDTH(8), .DIV(1), .BLINKS(2)) dut (
    .CLOCK (clk),
    .RESET (rst1),
    .EN    (en1),
    .MODE  (mode1),
    .LED   (led1),
    .WRAP  (wrap1)
  );

  led_pattern_seq #(.WIDTH(8), .DIV(4), .BLINKS(2)) dut_div4 (
    .CLOCK (clk),
    .RESET (rst4),
    .EN    (en4),
    .MODE  (mode4),
    .LED   (led4),
    .WRAP  (wrap4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  initial begin
    rst1 = 1'b1; en1 = 1'b0; mode1 = 2'd0;
    rst4 = 1'b1; en4 = 1'b0; mode4 = 2'd0;

    // Full show: reset pattern, whole loop, wrap back to the start
    step();
    rst1 = 1'b0;
    chk("show_reset_led", 32'(led1), 32'h01);
    chk("show_reset_wrap", 32'(wrap1), 32'd0);
    en1 = 1'b1;
    for (int i = 1; i < 36; i++) begin
      step();
      chk($sformatf("show_led_%0d", i), 32'(led1), 32'(show[i]));
      chk($sformatf("show_wrap_%0d", i), 32'(wrap1), 32'd0);
    end
    step();
    chk("show_loop_led", 32'(led1), 32'h01);
    chk("show_loop_wrap", 32'(wrap1), 32'd1);
    step();
    chk("show_after_led", 32'(led1), 32'h03);
    chk("show_after_wrap", 32'(wrap1), 32'd0);

    // Left bar with MODE changed mid-loop to blink
    mode1 = 2'd1; rst1 = 1'b1;
    step();
    rst1 = 1'b0;
    chk("lbar_reset_led", 32'(led1), 32'h01);
    for (int i = 1; i < 16; i++) begin
      step();
      chk($sformatf("lbar_led_%0d", i), 32'(led1), 32'(show[i]));
      chk($sformatf("lbar_wrap_%0d", i), 32'(wrap1), 32'd0);
      if (i == 5) mode1 = 2'd2;
    end
    step();
    chk("blink0_led", 32'(led1), 32'hFF);
    chk("blink0_wrap", 32'(wrap1), 32'd1);
    step();
    chk("blink1_led", 32'(led1), 32'h00);
    chk("blink1_wrap", 32'(wrap1), 32'd0);
    step();
    chk("blink2_led", 32'(led1), 32'hFF);
    step();
    chk("blink3_led", 32'(led1), 32'h00);
    chk("blink3_wrap", 32'(wrap1), 32'd0);
    step();
    chk("blink_loop_led", 32'(led1), 32'hFF);
    chk("blink_loop_wrap", 32'(wrap1), 32'd1);

    // Right bar with enable gaps
    mode1 = 2'd3; en1 = 1'b0; rst1 = 1'b1;
    step();
    rst1 = 1'b0;
    chk("rbar_reset_led", 32'(led1), 32'h80);
    step();
    chk("rbar_hold1_led", 32'(led1), 32'h80);
    chk("rbar_hold1_wrap", 32'(wrap1), 32'd0);
    step();
    chk("rbar_hold2_led", 32'(led1), 32'h80);
    en1 = 1'b1;
    step();
    chk("rbar_adv_led", 32'(led1), 32'hC0);
    chk("rbar_adv_wrap", 32'(wrap1), 32'd0);
    step();
    chk("rbar_adv2_led", 32'(led1), 32'hE0);

    // Reset mid-loop into blink mode
    mode1 = 2'd0; rst1 = 1'b1;
    step();
    rst1 = 1'b0;
    repeat (20) step();
    chk("midrst_pre_led", 32'(led1), 32'h80);
    mode1 = 2'd2; rst1 = 1'b1;
    step();
    rst1 = 1'b0;
    chk("midrst_led", 32'(led1), 32'hFF);
    chk("midrst_wrap", 32'(wrap1), 32'd0);
    step();
    chk("midrst_next_led", 32'(led1), 32'h00);
    step();
    step();
    chk("midrst_b3_led", 32'(led1), 32'h00);
    step();
    chk("midrst_loop_led", 32'(led1), 32'hFF);
    chk("midrst_loop_wrap", 32'(wrap1), 32'd1);

    // Step period of four enabled cycles
    mode4 = 2'd0; rst4 = 1'b1;
    step();
    rst4 = 1'b0; en4 = 1'b1;
    chk("div4_reset_led", 32'(led4), 32'h01);
    step(); step(); step();
    chk("div4_c3_led", 32'(led4), 32'h01);
    step();
    chk("div4_c4_led", 32'(led4), 32'h03);
    chk("div4_c4_wrap", 32'(wrap4), 32'd0);
    step(); step();
    en4 = 1'b0;
    step(); step();
    chk("div4_hold_led", 32'(led4), 32'h03);
    chk("div4_hold_wrap", 32'(wrap4), 32'd0);
    en4 = 1'b1;
    step();
    chk("div4_late_led", 32'(led4), 32'h03);
    step();
    chk("div4_step2_led", 32'(led4), 32'h07);

    // Reset in the middle of a timer count restarts the full period
    step(); step();
    rst4 = 1'b1;
    step();
    rst4 = 1'b0;
    chk("div4_rst_led", 32'(led4), 32'h01);
    step(); step(); step();
    chk("div4_rst_c3_led", 32'(led4), 32'h01);
    step();
    chk("div4_rst_c4_led", 32'(led4), 32'h03);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
